// File: rtl/io_ctrl_if.sv
// Data-memory-stage bus into the io_ctrl window.
// The CPU side is the master; io_ctrl is the slave that drives DOUT and HIT.
interface io_ctrl_if #(
    parameter int DBITS = 16
) ();
    logic [DBITS-1:0] ADDR;
    logic [DBITS-1:0] DIN;
    logic [DBITS-1:0] DOUT;
    logic             WE;
    logic             RE;
    logic             HIT;

    modport master (output ADDR, output WE, output RE, output DIN, input DOUT, input HIT);
    modport slave  (input ADDR, input WE, input RE, input DIN, output DOUT, output HIT);
endinterface

// File: rtl/io_ctrl.sv
// Memory-mapped key/switch/HEX/LED/timer controller in the top 16 bytes of data space.
// Optional feature macro: IO_IRQ_EN adds the KCTRL ie bit and a registered IRQ output.
module io_ctrl #(
    parameter int DBITS      = 16,
    parameter int NKEYS      = 4,
    parameter int NSW        = 10,
    parameter int NLEDR      = 10,
    parameter int NLEDG      = 8,
    parameter int DEB_CYCLES = 50000,
    parameter int TDIV       = 50000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    io_ctrl_if.slave         bus,
    input  logic [NKEYS-1:0] KEY,
    input  logic [NSW-1:0]   SW,
    output logic [DBITS-1:0] HEXVAL,
    output logic [NLEDR-1:0] LEDR,
    output logic [NLEDG-1:0] LEDG
`ifdef IO_IRQ_EN
    ,
    output logic             IRQ
`endif
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TW = (TDIV > 1) ? $clog2(TDIV) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TDIV_LAST = TW'(TDIV - 1);

    logic [NKEYS-1:0] r_key_s1, r_key_s2, r_key_smp, r_key_db, r_key_db_d;
    logic [NSW-1:0]   r_sw_s1, r_sw_s2, r_sw_smp, r_sw_db;
    logic [DW-1:0]    r_deb_cnt;
    logic [TW-1:0]    r_pre;
    logic [DBITS-1:0] r_tcnt;
    logic             r_rdy, r_ovr;
    logic             w_ie;
    logic             w_hit, w_wr, w_kclr, w_kchg, w_tick;
    logic [2:0]       w_off;
    logic [DBITS-1:0] w_dout;

    assign w_off  = bus.ADDR[3:1];
    assign w_hit  = &bus.ADDR[DBITS-1:4];
    assign w_wr   = bus.WE & w_hit;
    assign w_kclr = (bus.RE & w_hit & (w_off == 3'd0)) | (w_wr & (w_off == 3'd2));
    assign w_kchg = |(r_key_db ^ r_key_db_d);
    assign w_tick = (r_deb_cnt == DEB_LAST);
    assign bus.HIT  = w_hit;
    assign bus.DOUT = w_dout;

    // Synchronise raw inputs and accept a new level only when two consecutive samples agree.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_key_s1   <= {NKEYS{1'b1}};
            r_key_s2   <= {NKEYS{1'b1}};
            r_key_smp  <= {NKEYS{1'b1}};
            r_key_db   <= {NKEYS{1'b1}};
            r_key_db_d <= {NKEYS{1'b1}};
            r_sw_s1    <= {NSW{1'b0}};
            r_sw_s2    <= {NSW{1'b0}};
            r_sw_smp   <= {NSW{1'b0}};
            r_sw_db    <= {NSW{1'b0}};
            r_deb_cnt  <= {DW{1'b0}};
        end else begin
            r_key_s1   <= KEY;
            r_key_s2   <= r_key_s1;
            r_sw_s1    <= SW;
            r_sw_s2    <= r_sw_s1;
            r_key_db_d <= r_key_db;
            if (w_tick) begin
                r_deb_cnt <= {DW{1'b0}};
                r_key_db  <= (r_key_s2 & ~(r_key_s2 ^ r_key_smp)) | (r_key_db & (r_key_s2 ^ r_key_smp));
                r_sw_db   <= (r_sw_s2 & ~(r_sw_s2 ^ r_sw_smp)) | (r_sw_db & (r_sw_s2 ^ r_sw_smp));
                r_key_smp <= r_key_s2;
                r_sw_smp  <= r_sw_s2;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
        end
    end

    // Key-change status: a change event always sets rdy and only flags overrun when no clear coincides.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rdy <= 1'b0;
            r_ovr <= 1'b0;
        end else if (w_kchg) begin
            r_rdy <= 1'b1;
            r_ovr <= w_kclr ? 1'b0 : (r_ovr | r_rdy);
        end else if (w_kclr) begin
            r_rdy <= 1'b0;
            r_ovr <= 1'b0;
        end
    end

`ifdef IO_IRQ_EN
    logic r_ie;
    assign w_ie = r_ie;

    // Interrupt enable and registered interrupt request.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ie <= 1'b0;
            IRQ  <= 1'b0;
        end else begin
            if (w_wr && (w_off == 3'd2)) begin
                r_ie <= bus.DIN[4];
            end
            IRQ <= r_rdy & r_ie;
        end
    end
`else
    assign w_ie = 1'b0;
`endif

    // Prescaled timer; a CPU write overrides the increment in the same clock.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pre  <= {TW{1'b0}};
            r_tcnt <= {DBITS{1'b0}};
        end else if (w_wr && (w_off == 3'd3)) begin
            r_pre  <= {TW{1'b0}};
            r_tcnt <= bus.DIN;
        end else if (r_pre == TDIV_LAST) begin
            r_pre  <= {TW{1'b0}};
            r_tcnt <= r_tcnt + DBITS'(1);
        end else begin
            r_pre  <= r_pre + TW'(1);
        end
    end

    // Output registers written by the CPU.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HEXVAL <= {DBITS{1'b0}};
            LEDR   <= {NLEDR{1'b0}};
            LEDG   <= {NLEDG{1'b0}};
        end else if (w_wr) begin
            case (w_off)
                3'd4:    HEXVAL <= bus.DIN;
                3'd5:    LEDR   <= bus.DIN[NLEDR-1:0];
                3'd6:    LEDG   <= bus.DIN[NLEDG-1:0];
                default: ;
            endcase
        end
    end

    // Read mux; narrow registers zero-extend, unmapped slot returns a recognisable pattern.
    always_comb begin
        w_dout = {DBITS{1'b0}};
        if (w_hit) begin
            case (w_off)
                3'd0:    w_dout = DBITS'(r_key_db);
                3'd1:    w_dout = DBITS'(r_sw_db);
                3'd2:    w_dout = DBITS'({w_ie, 2'b00, r_ovr, r_rdy});
                3'd3:    w_dout = r_tcnt;
                3'd4:    w_dout = HEXVAL;
                3'd5:    w_dout = DBITS'(LEDR);
                3'd6:    w_dout = DBITS'(LEDG);
                default: w_dout = DBITS'(16'hDEAD);
            endcase
        end else begin
            w_dout = {DBITS{1'b0}};
        end
    end
endmodule
